// File: rtl/budget_round_robin_scheduler.sv
// rtl/budget_round_robin_scheduler.sv - budget-regulated round-robin grant scheduler for one memory port
module budget_round_robin_scheduler #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int BUDGET_WIDTH     = 16,
    parameter int PERIOD           = 1000,
    parameter int DEFAULT_BUDGET   = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUMBER_OF_QUEUES-1:0]         empty,
    input  logic                                cfg_write,
    input  logic [$clog2(NUMBER_OF_QUEUES)-1:0] cfg_queue,
    input  logic [BUDGET_WIDTH-1:0]             cfg_budget,
    input  logic                                grant_ready,
    output logic                                grant_valid,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0] selection,
    output logic [NUMBER_OF_QUEUES-1:0]         throttled,
    output logic                                period_start
);
    localparam int QW = $clog2(NUMBER_OF_QUEUES);
    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0]           LAST_COUNT   = CW'(PERIOD - 1);
    localparam logic [BUDGET_WIDTH-1:0] RESET_BUDGET = BUDGET_WIDTH'(DEFAULT_BUDGET);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state;
    logic [CW-1:0]           period_count;
    logic [CW-1:0]           period_count_next;
    logic [QW-1:0]           last;
    logic [BUDGET_WIDTH-1:0] cfg         [NUMBER_OF_QUEUES];
    logic [BUDGET_WIDTH-1:0] budget      [NUMBER_OF_QUEUES];
    logic [BUDGET_WIDTH-1:0] cfg_next    [NUMBER_OF_QUEUES];
    logic [BUDGET_WIDTH-1:0] budget_next [NUMBER_OF_QUEUES];
    logic [NUMBER_OF_QUEUES-1:0] eligible;
    logic                    reload;
    logic                    accept;
    logic                    pick_found;
    logic [QW-1:0]           pick_index;
    logic [QW-1:0]           candidate;

    assign reload            = (period_count == LAST_COUNT);
    assign accept            = (state == GRANT) && grant_ready;
    assign period_count_next = reload ? '0 : period_count + CW'(1);

    // Scan last+1 .. last+N; the QW-bit add wraps modulo the power-of-two queue count.
    always_comb begin
        eligible   = '0;
        pick_found = 1'b0;
        pick_index = '0;
        candidate  = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            eligible[i] = ~empty[i] & (budget[i] != '0);
        end
        for (int k = 1; k <= NUMBER_OF_QUEUES; k++) begin
            candidate = last + QW'(k);
            if (!pick_found && eligible[candidate]) begin
                pick_found = 1'b1;
                pick_index = candidate;
            end
        end
    end

    // Reload beats the charge of a grant accepted on the same edge.
    always_comb begin
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            cfg_next[i]    = (cfg_write && (cfg_queue == QW'(i))) ? cfg_budget : cfg[i];
            budget_next[i] = budget[i];
            if (reload) begin
                budget_next[i] = cfg_next[i];
            end else if (accept && (selection == QW'(i)) && (budget[i] != '0)) begin
                budget_next[i] = budget[i] - BUDGET_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            grant_valid  <= 1'b0;
            selection    <= '0;
            last         <= QW'(NUMBER_OF_QUEUES - 1);
            period_count <= '0;
            period_start <= 1'b0;
            throttled    <= '0;
            for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
                cfg[i]    <= RESET_BUDGET;
                budget[i] <= RESET_BUDGET;
            end
        end else begin
            period_count <= period_count_next;
            period_start <= (period_count_next == LAST_COUNT);
            for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
                cfg[i]       <= cfg_next[i];
                budget[i]    <= budget_next[i];
                throttled[i] <= (budget_next[i] == '0);
            end
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        selection   <= pick_index;
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        last        <= selection;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_budget_round_robin_scheduler.sv
// tb/tb_budget_round_robin_scheduler.sv - vector table, directed sequences and random stimulus against a reference model
module tb_budget_round_robin_scheduler;
    localparam int NQ  = 4;
    localparam int BW  = 16;
    localparam int PER = 200;
    localparam int DEF = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [NQ-1:0] empty;
    logic          cfg_write;
    logic [1:0]    cfg_queue;
    logic [BW-1:0] cfg_budget;
    logic          grant_ready;
    logic          grant_valid;
    logic [1:0]    selection;
    logic [NQ-1:0] throttled;
    logic          period_start;

    int compared   = 0;
    int mismatched = 0;

    int m_cfg [NQ];
    int m_bud [NQ];
    bit m_valid;
    int m_sel;
    int m_last;
    int m_t;
    bit m_ps;

    typedef struct {
        logic [NQ-1:0] empty;
        logic          ready;
        logic          exp_valid;
        int            exp_sel;
    } vec_t;
    vec_t vecs [21];

    budget_round_robin_scheduler #(
        .NUMBER_OF_QUEUES(NQ),
        .BUDGET_WIDTH(BW),
        .PERIOD(PER),
        .DEFAULT_BUDGET(DEF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .empty(empty),
        .cfg_write(cfg_write),
        .cfg_queue(cfg_queue),
        .cfg_budget(cfg_budget),
        .grant_ready(grant_ready),
        .grant_valid(grant_valid),
        .selection(selection),
        .throttled(throttled),
        .period_start(period_start)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int m_throttled();
        int v = 0;
        for (int i = 0; i < NQ; i++) if (m_bud[i] == 0) v |= (1 << i);
        return v;
    endfunction

    // Model of the scheduling rules, evaluated with the inputs present before the coming edge.
    task automatic model_step();
        int nb [NQ];
        bit rl;
        if (reset) begin
            for (int i = 0; i < NQ; i++) begin
                m_cfg[i] = DEF;
                m_bud[i] = DEF;
            end
            m_valid = 0; m_sel = 0; m_last = NQ - 1; m_t = 0; m_ps = 0;
            return;
        end
        rl = ((m_t % PER) == PER - 1);
        if (cfg_write) m_cfg[cfg_queue] = int'(cfg_budget);
        for (int i = 0; i < NQ; i++) nb[i] = rl ? m_cfg[i] : m_bud[i];
        if (!rl && m_valid && grant_ready && nb[m_sel] > 0) nb[m_sel] = nb[m_sel] - 1;
        if (m_valid) begin
            if (grant_ready) begin
                m_valid = 0;
                m_last  = m_sel;
            end
        end else begin
            for (int k = 1; k <= NQ; k++) begin
                int q = (m_last + k) % NQ;
                if (!m_valid && !empty[q] && m_bud[q] != 0) begin
                    m_valid = 1;
                    m_sel   = q;
                end
            end
        end
        for (int i = 0; i < NQ; i++) m_bud[i] = nb[i];
        m_t++;
        m_ps = ((m_t % PER) == PER - 1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_model(input string tag);
        check($sformatf("%s grant_valid", tag), int'(grant_valid), int'(m_valid));
        if (m_valid) check($sformatf("%s selection", tag), int'(selection), m_sel);
        check($sformatf("%s throttled", tag), int'(throttled), m_throttled());
        check($sformatf("%s period_start", tag), int'(period_start), int'(m_ps));
        for (int i = 0; i < NQ; i++)
            check($sformatf("%s budget%0d", tag, i), int'(dut.budget[i]), m_bud[i]);
    endtask

    initial begin
        int n, grants, guard, p;
        int cnt [2];
        int exp_bud [NQ];

        vecs[0]  = '{4'b1010, 1'b1, 1'b1, 0};
        vecs[1]  = '{4'b1010, 1'b1, 1'b0, 0};
        vecs[2]  = '{4'b1010, 1'b1, 1'b1, 2};
        vecs[3]  = '{4'b1010, 1'b1, 1'b0, 0};
        vecs[4]  = '{4'b1010, 1'b1, 1'b1, 0};
        vecs[5]  = '{4'b1010, 1'b1, 1'b0, 0};
        vecs[6]  = '{4'b1010, 1'b1, 1'b1, 2};
        vecs[7]  = '{4'b1010, 1'b1, 1'b0, 0};
        vecs[8]  = '{4'b0000, 1'b1, 1'b1, 3};
        vecs[9]  = '{4'b0000, 1'b1, 1'b0, 0};
        vecs[10] = '{4'b0000, 1'b1, 1'b1, 0};
        vecs[11] = '{4'b0000, 1'b1, 1'b0, 0};
        vecs[12] = '{4'b0000, 1'b1, 1'b1, 1};
        vecs[13] = '{4'b0000, 1'b1, 1'b0, 0};
        vecs[14] = '{4'b0000, 1'b1, 1'b1, 2};
        vecs[15] = '{4'b0000, 1'b1, 1'b0, 0};
        vecs[16] = '{4'b0000, 1'b0, 1'b1, 3};
        vecs[17] = '{4'b0000, 1'b0, 1'b1, 3};
        vecs[18] = '{4'b1111, 1'b0, 1'b1, 3};
        vecs[19] = '{4'b1111, 1'b1, 1'b0, 0};
        vecs[20] = '{4'b1111, 1'b1, 1'b0, 0};
        exp_bud = '{5, 7, 5, 6};

        reset = 1'b1; empty = '1; cfg_write = 1'b0; cfg_queue = '0; cfg_budget = '0; grant_ready = 1'b0;
        tick();
        check("reset grant_valid", int'(grant_valid), 0);
        check("reset selection", int'(selection), 0);
        check("reset throttled", int'(throttled), 0);
        check("reset period_start", int'(period_start), 0);
        reset = 1'b0;

        for (int v = 0; v < 21; v++) begin
            empty = vecs[v].empty;
            grant_ready = vecs[v].ready;
            tick();
            check($sformatf("table row %0d grant_valid", v), int'(grant_valid), int'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) check($sformatf("table row %0d selection", v), int'(selection), vecs[v].exp_sel);
            check($sformatf("table row %0d throttled", v), int'(throttled), 0);
            if (v == 7) begin
                check("skipped queue1 budget", int'(dut.budget[1]), DEF);
                check("skipped queue3 budget", int'(dut.budget[3]), DEF);
            end
        end
        for (int i = 0; i < NQ; i++)
            check($sformatf("table end budget%0d", i), int'(dut.budget[i]), exp_bud[i]);

        // Grant to queue 2 held under backpressure while its request disappears.
        empty = 4'b1011; grant_ready = 1'b0;
        tick();
        check("hold first valid", int'(grant_valid), 1);
        check("hold first selection", int'(selection), 2);
        empty = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold grant_valid", int'(grant_valid), 1);
            check("hold selection", int'(selection), 2);
            check("hold budget2", int'(dut.budget[2]), 5);
        end
        grant_ready = 1'b1;
        tick();
        check("hold release valid", int'(grant_valid), 0);
        check("hold release budget2", int'(dut.budget[2]), 4);

        // Exhaust every budget, then wait for the reload.
        reset = 1'b1; tick(); reset = 1'b0;
        empty = 4'b0000; grant_ready = 1'b1;
        n = 0; grants = 0;
        while (grants < 32 && n < 100) begin
            tick(); n++;
            check_model("rotate");
            if (grant_valid) begin
                check("rotate order", int'(selection), grants % NQ);
                grants++;
            end
        end
        check("rotate grant count", grants, 32);
        check("rotate last gap", n, 63);
        tick(); n++;
        check("exhausted throttled", int'(throttled), 4'b1111);
        guard = 0;
        while (!period_start && guard < PER + 10) begin
            tick(); n++; guard++;
            check("throttled grant_valid", int'(grant_valid), 0);
        end
        check("first period_start seen", int'(period_start), 1);
        check("first period_start cycle", n, PER - 1);
        tick();
        check("reload throttled", int'(throttled), 0);
        check("reload grant_valid", int'(grant_valid), 0);
        tick();
        check("post reload valid", int'(grant_valid), 1);
        check("post reload selection", int'(selection), 0);

        // Config write mid-period applies from the next period.
        reset = 1'b1; tick(); reset = 1'b0;
        empty = 4'b1101; grant_ready = 1'b1;
        cnt = '{0, 0}; p = 0; guard = 0;
        while (p < 2 && guard < 2 * PER + 10) begin
            cfg_write = (guard == 5); cfg_queue = 2'd1; cfg_budget = 16'd3;
            tick(); guard++;
            check_model("cfg");
            if (grant_valid && selection == 2'd1) cnt[p]++;
            if (period_start) p++;
        end
        cfg_write = 1'b0;
        check("cfg periods reached", p, 2);
        check("cfg grants old period", cnt[0], 8);
        check("cfg grants new period", cnt[1], 3);

        // Accept on the reload cycle is not charged.
        reset = 1'b1; tick(); reset = 1'b0;
        empty = 4'b1110; grant_ready = 1'b0;
        guard = 0;
        while (!period_start && guard < PER + 10) begin
            tick(); guard++;
            check_model("reload accept");
        end
        check("reload accept period_start", int'(period_start), 1);
        check("reload accept pending", int'(grant_valid), 1);
        grant_ready = 1'b1;
        tick();
        check("reload accept budget0", int'(dut.budget[0]), 8);
        check("reload accept valid", int'(grant_valid), 0);

        // Reset mid-handshake drops the grant without charging it.
        empty = 4'b0000;
        for (int c = 0; c < 6; c++) tick();
        grant_ready = 1'b0;
        tick(); tick();
        check("pre reset pending", int'(grant_valid), 1);
        reset = 1'b1;
        tick();
        check("mid reset valid", int'(grant_valid), 0);
        check("mid reset throttled", int'(throttled), 0);
        for (int i = 0; i < NQ; i++) check($sformatf("mid reset budget%0d", i), int'(dut.budget[i]), DEF);
        reset = 1'b0;
        tick();
        check("after reset valid", int'(grant_valid), 1);
        check("after reset selection", int'(selection), 0);

        // Random traffic against the model.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            empty       = NQ'($urandom);
            grant_ready = ($urandom_range(0, 3) != 0);
            cfg_write   = ($urandom_range(0, 15) == 0);
            cfg_queue   = 2'($urandom);
            cfg_budget  = BW'($urandom_range(0, 6));
            reset       = ($urandom_range(0, 499) == 0);
            tick();
            check_model("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
